// File: rtl/vec_vsetvl_unit.sv
// vsetvli / vsetivli / vsetvl resolver: decodes the instruction, computes the new vl and vtype,
// drives the vector CSR write port and returns the new vl to the scalar core (IDLE -> CALC -> WB).
module vec_vsetvl_unit #(
   parameter int XLEN = 32,
   parameter int VLEN = 512,
   parameter int ELEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [XLEN-1:0] inst,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic [XLEN-1:0] cur_vl,
   output logic [XLEN-1:0] scalar1,
   output logic [XLEN-1:0] scalar2,
   output logic            csrwr_en,
   output logic            rd_valid,
   input  logic            rd_ready,
   output logic [4:0]      rd_addr,
   output logic [XLEN-1:0] rd_data,
   output logic            illegal
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] WB   = 2'd2;

   localparam logic [XLEN-1:0] VILL_VTYPE = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] VLEN_X     = XLEN'(VLEN);
   localparam logic [XLEN-1:0] ELEN_X     = XLEN'(ELEN);
   localparam logic [XLEN-1:0] SEW_BASE   = XLEN'(8);

   // VLMAX = VLEN / SEW * LMUL, expressed as shifts so no divider is built
   function automatic logic [XLEN-1:0] vlmax_f(input logic [1:0] vsew, input logic [1:0] vlmul);
      vlmax_f = (VLEN_X >> (3'd3 + {1'b0, vsew})) << vlmul;
   endfunction

   logic [1:0]      state_r;
   logic            req_ready_r;
   logic [XLEN-1:0] inst_r;
   logic [XLEN-1:0] rs1_r;
   logic [XLEN-1:0] rs2_r;
   logic [XLEN-1:0] cur_vl_r;

   logic [XLEN-1:0] scalar1_r;
   logic [XLEN-1:0] scalar2_r;
   logic            csrwr_en_r;
   logic            rd_valid_r;
   logic [4:0]      rd_addr_r;
   logic [XLEN-1:0] rd_data_r;
   logic            illegal_r;

   logic            vset_op_s;
   logic            legal_s;
   logic [XLEN-1:0] vtype_s;
   logic [XLEN-1:0] avl_s;
   logic [XLEN-1:0] sew_s;
   logic [XLEN-1:0] vlmax_s;
   logic            vill_s;
   logic [XLEN-1:0] vl_s;
   logic [XLEN-1:0] vtype_out_s;
   logic            unused_s;

   assign vset_op_s = (inst_r[6:0] == 7'h57) && (inst_r[14:12] == 3'b111);

   // Decode the latched instruction and compute vl / vtype for the CALC cycle
   always_comb begin
      legal_s     = 1'b0;
      vtype_s     = '0;
      avl_s       = '0;
      vl_s        = '0;
      vtype_out_s = VILL_VTYPE;

      if (vset_op_s && (inst_r[31] == 1'b0)) begin
         legal_s = 1'b1;
         vtype_s = {{(XLEN-11){1'b0}}, inst_r[30:20]};
      end else if (vset_op_s && (inst_r[31:30] == 2'b11)) begin
         legal_s = 1'b1;
         vtype_s = {{(XLEN-10){1'b0}}, inst_r[29:20]};
      end else if (vset_op_s && (inst_r[31:25] == 7'b1000000)) begin
         legal_s = 1'b1;
         vtype_s = rs2_r;
      end else begin
         legal_s = 1'b0;
         vtype_s = '0;
      end

      // rs1 = x0 means "VLMAX" when writing a register, "keep vl" otherwise
      if (inst_r[31:30] == 2'b11) begin
         avl_s = {{(XLEN-5){1'b0}}, inst_r[19:15]};
      end else if (inst_r[19:15] != 5'd0) begin
         avl_s = rs1_r;
      end else if (inst_r[11:7] != 5'd0) begin
         avl_s = '1;
      end else begin
         avl_s = cur_vl_r;
      end

      if (vill_s) begin
         vl_s        = '0;
         vtype_out_s = VILL_VTYPE;
      end else if (avl_s <= vlmax_s) begin
         vl_s        = avl_s;
         vtype_out_s = {{(XLEN-8){1'b0}}, vtype_s[7:0]};
      end else begin
         vl_s        = vlmax_s;
         vtype_out_s = {{(XLEN-8){1'b0}}, vtype_s[7:0]};
      end
   end

   assign sew_s    = SEW_BASE << vtype_s[4:3];
   assign vlmax_s  = vlmax_f(vtype_s[4:3], vtype_s[1:0]);
   assign vill_s   = vtype_s[5] | vtype_s[2] | (sew_s > ELEN_X) | (|vtype_s[XLEN-2:8]);
   assign unused_s = vtype_s[XLEN-1];

   // Control FSM and operand capture at the request handshake
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         req_ready_r <= 1'b1;
         inst_r      <= '0;
         rs1_r       <= '0;
         rs2_r       <= '0;
         cur_vl_r    <= '0;
      end else begin
         case (state_r)
            IDLE: begin
               if (req_valid && req_ready_r) begin
                  inst_r      <= inst;
                  rs1_r       <= rs1_data;
                  rs2_r       <= rs2_data;
                  cur_vl_r    <= cur_vl;
                  state_r     <= CALC;
                  req_ready_r <= 1'b0;
               end
            end
            CALC: begin
               state_r     <= WB;
               req_ready_r <= 1'b0;
            end
            WB: begin
               if (rd_ready) begin
                  state_r     <= IDLE;
                  req_ready_r <= 1'b1;
               end
            end
            default: begin
               state_r     <= IDLE;
               req_ready_r <= 1'b1;
            end
         endcase
      end
   end

   // Result registers; the CSR strobe fires only on the CALC -> WB edge
   always_ff @(posedge clk) begin
      if (rst) begin
         scalar1_r  <= '0;
         scalar2_r  <= VILL_VTYPE;
         csrwr_en_r <= 1'b0;
         rd_valid_r <= 1'b0;
         rd_addr_r  <= 5'd0;
         rd_data_r  <= '0;
         illegal_r  <= 1'b0;
      end else begin
         csrwr_en_r <= 1'b0;
         case (state_r)
            CALC: begin
               scalar1_r  <= legal_s ? vl_s : '0;
               scalar2_r  <= legal_s ? vtype_out_s : VILL_VTYPE;
               rd_data_r  <= legal_s ? vl_s : '0;
               rd_addr_r  <= inst_r[11:7];
               illegal_r  <= ~legal_s;
               csrwr_en_r <= legal_s;
               rd_valid_r <= 1'b1;
            end
            WB: begin
               rd_valid_r <= ~rd_ready;
            end
            default: begin
               rd_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready = req_ready_r;
   assign scalar1   = scalar1_r;
   assign scalar2   = scalar2_r;
   assign csrwr_en  = csrwr_en_r;
   assign rd_valid  = rd_valid_r;
   assign rd_addr   = rd_addr_r;
   assign rd_data   = rd_data_r;
   assign illegal   = illegal_r;

endmodule

// File: tb/tb_vec_vsetvl_unit.sv
// Self-checking bench for vec_vsetvl_unit: directed scenarios plus randomized instructions
// checked against an arithmetic reference model of the vset* rules.
module tb_vec_vsetvl_unit;

   localparam int XLEN = 32;
   localparam int VLEN = 512;
   localparam int ELEN = 32;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] inst;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic [31:0] cur_vl;
   logic [31:0] scalar1;
   logic [31:0] scalar2;
   logic        csrwr_en;
   logic        rd_valid;
   logic        rd_ready;
   logic [4:0]  rd_addr;
   logic [31:0] rd_data;
   logic        illegal;

   int n_vec = 0;
   int n_err = 0;

   vec_vsetvl_unit #(.XLEN(XLEN), .VLEN(VLEN), .ELEN(ELEN)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .inst(inst), .rs1_data(rs1_data), .rs2_data(rs2_data), .cur_vl(cur_vl),
      .scalar1(scalar1), .scalar2(scalar2), .csrwr_en(csrwr_en),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
      .rd_data(rd_data), .illegal(illegal)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference: decode, AVL selection and VLMAX = VLEN*LMUL/SEW in plain arithmetic
   function automatic void ref_model(input logic [31:0] i, input logic [31:0] r1,
                                     input logic [31:0] r2, input logic [31:0] cv,
                                     output bit m_ill, output logic [31:0] m_vl,
                                     output logic [31:0] m_vt);
      logic [31:0] vt;
      logic [31:0] avl;
      longint unsigned sew_bits;
      longint unsigned vlmax;
      bit vill;
      m_ill = !((i[6:0] == 7'h57) && (i[14:12] == 3'b111) &&
                (i[31] == 1'b0 || i[31:30] == 2'b11 || i[31:25] == 7'b1000000));
      m_vl = 32'd0;
      m_vt = 32'h8000_0000;
      if (!m_ill) begin
         if (i[31] == 1'b0) vt = {21'd0, i[30:20]};
         else if (i[31:30] == 2'b11) vt = {22'd0, i[29:20]};
         else vt = r2;
         if (i[31:30] == 2'b11) avl = {27'd0, i[19:15]};
         else if (i[19:15] == 5'd0) avl = (i[11:7] != 5'd0) ? 32'hFFFF_FFFF : cv;
         else avl = r1;
         sew_bits = 64'd8 * (64'd2 ** int'(vt[5:3]));
         vill = (vt[2] == 1'b1) || (vt[30:8] != 23'd0) || (sew_bits > longint'(ELEN));
         if (!vill) begin
            vlmax = longint'(VLEN) * (64'd2 ** int'(vt[1:0])) / sew_bits;
            m_vl  = (longint'(avl) <= vlmax) ? avl : vlmax[31:0];
            m_vt  = {24'd0, vt[7:0]};
         end
      end
   endfunction

   // Offer one instruction, follow it through CALC/WB, and report what was observed
   task automatic do_op(input logic [31:0] i, input logic [31:0] r1, input logic [31:0] r2,
                        input logic [31:0] cv, input int stall,
                        output logic [31:0] o_data, output logic [31:0] o_s1,
                        output logic [31:0] o_s2, output logic o_ill, output logic [4:0] o_addr,
                        output int o_csr, output int o_lat, output bit o_stable,
                        output bit o_idle, output bit o_to, output time o_acc);
      int w;
      o_csr = 0; o_stable = 1'b1; o_to = 1'b0; o_lat = 0; w = 0;
      inst = i; rs1_data = r1; rs2_data = r2; cur_vl = cv;
      rd_ready = (stall == 0); req_valid = 1'b1;
      while (req_ready !== 1'b1 && w < 20) begin
         @(posedge clk); #1; w++;
      end
      if (w >= 20) o_to = 1'b1;
      @(posedge clk); o_acc = $time; #1;
      req_valid = 1'b0;
      inst = 32'h0; rs1_data = ~r1; rs2_data = ~r2; cur_vl = ~cv;
      o_lat = 1;
      while (rd_valid !== 1'b1 && o_lat < 20) begin
         if (csrwr_en === 1'b1) o_csr++;
         @(posedge clk); #1; o_lat++;
      end
      if (o_lat >= 20) o_to = 1'b1;
      o_data = rd_data; o_s1 = scalar1; o_s2 = scalar2; o_ill = illegal; o_addr = rd_addr;
      if (csrwr_en === 1'b1) o_csr++;
      for (int k = 1; k <= stall; k++) begin
         @(posedge clk); #1;
         if (csrwr_en === 1'b1) o_csr++;
         if (rd_valid !== 1'b1 || rd_data !== o_data || scalar1 !== o_s1 ||
             scalar2 !== o_s2 || illegal !== o_ill || req_ready !== 1'b0) o_stable = 1'b0;
         if (k == stall) rd_ready = 1'b1;
      end
      @(posedge clk); #1;
      if (csrwr_en === 1'b1) o_csr++;
      o_idle = (rd_valid === 1'b0) && (req_ready === 1'b1);
   endtask

   logic [31:0] g_data, g_s1, g_s2;
   logic        g_ill;
   logic [4:0]  g_addr;
   int          g_csr, g_lat;
   bit          g_stable, g_idle, g_to;
   time         g_acc;

   task automatic test_reset;
      rst = 1'b1; req_valid = 1'b0; rd_ready = 1'b1;
      inst = 32'h0; rs1_data = 32'h0; rs2_data = 32'h0; cur_vl = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
      n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
      n_vec++; if (csrwr_en !== 1'b0) begin n_err++; $display("FAIL reset_csrwr got %b want 0", csrwr_en); end
      n_vec++; if (illegal !== 1'b0) begin n_err++; $display("FAIL reset_illegal got %b want 0", illegal); end
      n_vec++; if (scalar1 !== 32'h0) begin n_err++; $display("FAIL reset_scalar1 got %h want 0", scalar1); end
      n_vec++; if (scalar2 !== 32'h8000_0000) begin n_err++; $display("FAIL reset_scalar2 got %h want 80000000", scalar2); end
      n_vec++; if (rd_data !== 32'h0 || rd_addr !== 5'd0) begin n_err++; $display("FAIL reset_rd got %h/%h want 0/0", rd_data, rd_addr); end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_vsetvli;
      // vsetvli x1, x5, e32 m1
      do_op({1'b0, 11'h010, 5'd5, 3'b111, 5'd1, 7'h57}, 32'd100, 32'd0, 32'd0, 0,
            g_data, g_s1, g_s2, g_ill, g_addr, g_csr, g_lat, g_stable, g_idle, g_to, g_acc);
      n_vec++; if (g_to) begin n_err++; $display("FAIL vsetvli_timeout got timeout want response"); end
      n_vec++; if (g_s1 !== 32'd16) begin n_err++; $display("FAIL vsetvli_scalar1 got %0d want 16", g_s1); end
      n_vec++; if (g_s2 !== 32'h10) begin n_err++; $display("FAIL vsetvli_scalar2 got %h want 10", g_s2); end
      n_vec++; if (g_data !== 32'd16 || g_addr !== 5'd1) begin n_err++; $display("FAIL vsetvli_rd got %0d/x%0d want 16/x1", g_data, g_addr); end
      n_vec++; if (g_csr != 1) begin n_err++; $display("FAIL vsetvli_csrwr got %0d pulses want 1", g_csr); end
      n_vec++; if (g_lat != 2) begin n_err++; $display("FAIL vsetvli_latency got %0d want 2", g_lat); end
      n_vec++; if (!g_idle) begin n_err++; $display("FAIL vsetvli_return_idle got busy want idle"); end
      do_op({1'b0, 11'h010, 5'd5, 3'b111, 5'd1, 7'h57}, 32'd10, 32'd0, 32'd0, 0,
            g_data, g_s1, g_s2, g_ill, g_addr, g_csr, g_lat, g_stable, g_idle, g_to, g_acc);
      n_vec++; if (g_data !== 32'd10 || g_s1 !== 32'd10) begin n_err++; $display("FAIL vsetvli_small_avl got %0d/%0d want 10", g_data, g_s1); end
   endtask

   task automatic test_vsetivli_and_vlmax;
      do_op({2'b11, 10'h009, 5'd7, 3'b111, 5'd2, 7'h57}, 32'd999, 32'd0, 32'd0, 0,
            g_data, g_s1, g_s2, g_ill, g_addr, g_csr, g_lat, g_stable, g_idle, g_to, g_acc);
      n_vec++; if (g_data !== 32'd7 || g_s2 !== 32'h9) begin n_err++; $display("FAIL vsetivli got vl %0d vtype %h want 7/9", g_data, g_s2); end
      do_op({1'b0, 11'h003, 5'd0, 3'b111, 5'd3, 7'h57}, 32'd1, 32'd0, 32'd1, 0,
            g_data, g_s1, g_s2, g_ill, g_addr, g_csr, g_lat, g_stable, g_idle, g_to, g_acc);
      n_vec++; if (g_data !== 32'd512 || g_s1 !== 32'd512) begin n_err++; $display("FAIL e8m8_vlmax got %0d want 512", g_data); end
   endtask

   task automatic test_keep_vl;
      do_op({1'b0, 11'h010, 5'd0, 3'b111, 5'd0, 7'h57}, 32'd77, 32'd0, 32'd5, 0,
            g_data, g_s1, g_s2, g_ill, g_addr, g_csr, g_lat, g_stable, g_idle, g_to, g_acc);
      n_vec++; if (g_s1 !== 32'd5) begin n_err++; $display("FAIL keep_vl_5 got %0d want 5", g_s1); end
      do_op({1'b0, 11'h010, 5'd0, 3'b111, 5'd0, 7'h57}, 32'd3, 32'd0, 32'd40, 0,
            g_data, g_s1, g_s2, g_ill, g_addr, g_csr, g_lat, g_stable, g_idle, g_to, g_acc);
      n_vec++; if (g_s1 !== 32'd16) begin n_err++; $display("FAIL keep_vl_40 got %0d want 16", g_s1); end
   endtask

   task automatic test_illegal_vtype;
      do_op({1'b0, 11'h018, 5'd5, 3'b111, 5'd4, 7'h57}, 32'd8, 32'd0, 32'd0, 0,
            g_data, g_s1, g_s2, g_ill, g_addr, g_csr, g_lat, g_stable, g_idle, g_to, g_acc);
      n_vec++; if (g_s2 !== 32'h8000_0000 || g_s1 !== 32'd0) begin n_err++; $display("FAIL e64_vill got %h/%0d want 80000000/0", g_s2, g_s1); end
      n_vec++; if (g_csr != 1 || g_ill !== 1'b0) begin n_err++; $display("FAIL e64_csrwr got %0d pulses illegal %b want 1/0", g_csr, g_ill); end
      do_op({7'b1000000, 5'd2, 5'd5, 3'b111, 5'd1, 7'h57}, 32'd8, 32'h100, 32'd0, 0,
            g_data, g_s1, g_s2, g_ill, g_addr, g_csr, g_lat, g_stable, g_idle, g_to, g_acc);
      n_vec++; if (g_s2 !== 32'h8000_0000 || g_data !== 32'd0) begin n_err++; $display("FAIL vsetvl_reserved got %h/%0d want 80000000/0", g_s2, g_data); end
   endtask

   task automatic test_backpressure;
      do_op({1'b0, 11'h010, 5'd5, 3'b111, 5'd9, 7'h57}, 32'd12, 32'd0, 32'd0, 4,
            g_data, g_s1, g_s2, g_ill, g_addr, g_csr, g_lat, g_stable, g_idle, g_to, g_acc);
      n_vec++; if (g_csr != 1) begin n_err++; $display("FAIL bp_csrwr got %0d pulses want 1", g_csr); end
      n_vec++; if (!g_stable) begin n_err++; $display("FAIL bp_stable got unstable want stable"); end
      n_vec++; if (g_data !== 32'd12 || !g_idle) begin n_err++; $display("FAIL bp_result got %0d idle %b want 12/1", g_data, g_idle); end
      do_op({25'h1ABCDE, 7'h33}, 32'd5, 32'd0, 32'd0, 1,
            g_data, g_s1, g_s2, g_ill, g_addr, g_csr, g_lat, g_stable, g_idle, g_to, g_acc);
      n_vec++; if (g_ill !== 1'b1 || g_data !== 32'd0) begin n_err++; $display("FAIL illegal_op got %b/%0d want 1/0", g_ill, g_data); end
      n_vec++; if (g_csr != 0) begin n_err++; $display("FAIL illegal_op_csrwr got %0d pulses want 0", g_csr); end
   endtask

   task automatic test_back_to_back;
      time t0;
      do_op({1'b0, 11'h010, 5'd5, 3'b111, 5'd1, 7'h57}, 32'd3, 32'd0, 32'd0, 0,
            g_data, g_s1, g_s2, g_ill, g_addr, g_csr, g_lat, g_stable, g_idle, g_to, g_acc);
      t0 = g_acc;
      do_op({2'b11, 10'h008, 5'd31, 3'b111, 5'd2, 7'h57}, 32'd0, 32'd0, 32'd0, 0,
            g_data, g_s1, g_s2, g_ill, g_addr, g_csr, g_lat, g_stable, g_idle, g_to, g_acc);
      n_vec++; if (g_acc - t0 != 30) begin n_err++; $display("FAIL b2b_interval got %0t want 30", g_acc - t0); end
      n_vec++; if (g_data !== 32'd31) begin n_err++; $display("FAIL b2b_vl got %0d want 31", g_data); end
   endtask

   task automatic test_reset_mid;
      int pulses;
      int w;
      pulses = 0; w = 0;
      inst = {1'b0, 11'h010, 5'd5, 3'b111, 5'd1, 7'h57}; rs1_data = 32'd9; rd_ready = 1'b1;
      req_valid = 1'b1;
      while (req_ready !== 1'b1 && w < 20) begin @(posedge clk); #1; w++; end
      @(posedge clk); #1;
      req_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      n_vec++; if (req_ready !== 1'b1 || rd_valid !== 1'b0 || csrwr_en !== 1'b0) begin n_err++; $display("FAIL rst_mid_ctrl got rr%b rv%b cw%b want 1/0/0", req_ready, rd_valid, csrwr_en); end
      n_vec++; if (scalar1 !== 32'd0 || scalar2 !== 32'h8000_0000 || rd_data !== 32'd0) begin n_err++; $display("FAIL rst_mid_data got %h/%h/%h want 0/80000000/0", scalar1, scalar2, rd_data); end
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         if (csrwr_en === 1'b1 || rd_valid === 1'b1) pulses++;
      end
      n_vec++; if (pulses != 0) begin n_err++; $display("FAIL rst_mid_discard got %0d activity cycles want 0", pulses); end
   endtask

   task automatic test_random;
      logic [31:0] i, r1, r2, cv, m_vl, m_vt;
      logic [7:0]  vt8;
      logic [4:0]  rs1f, rdf;
      bit m_ill;
      int kind, stall;
      for (int n = 0; n < 80; n++) begin
         kind = $urandom_range(0, 4);
         vt8  = {$urandom_range(0, 3) == 0 ? 3'($urandom) : {1'b0, 2'($urandom)}, 5'($urandom)};
         if ($urandom_range(0, 3) != 0) vt8[2] = 1'b0;
         if ($urandom_range(0, 3) != 0) vt8[5] = 1'b0;
         rs1f = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom);
         rdf  = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom);
         r1   = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 600)) : $urandom;
         cv   = 32'($urandom_range(0, 600));
         r2   = {$urandom_range(0, 1) == 1, ($urandom_range(0, 4) == 0) ? 23'($urandom) : 23'd0, vt8};
         case (kind)
            0: i = {1'b0, ($urandom_range(0, 4) == 0) ? 3'($urandom) : 3'd0, vt8, rs1f, 3'b111, rdf, 7'h57};
            1: i = {2'b11, 2'd0, vt8, rs1f, 3'b111, rdf, 7'h57};
            2: i = {7'b1000000, 5'($urandom), rs1f, 3'b111, rdf, 7'h57};
            3: i = {$urandom_range(0, 1) == 0 ? 25'($urandom) : {10'($urandom), rs1f, 3'($urandom_range(0, 6)), rdf}, 7'h33};
            default: i = {7'b1000001, 5'($urandom), rs1f, 3'b111, rdf, 7'h57};
         endcase
         stall = $urandom_range(0, 2);
         ref_model(i, r1, r2, cv, m_ill, m_vl, m_vt);
         do_op(i, r1, r2, cv, stall,
               g_data, g_s1, g_s2, g_ill, g_addr, g_csr, g_lat, g_stable, g_idle, g_to, g_acc);
         n_vec++; if (g_ill !== m_ill || g_data !== m_vl || g_addr !== i[11:7]) begin n_err++; $display("FAIL rand_rd inst %h got ill%b vl%0d x%0d want ill%b vl%0d x%0d", i, g_ill, g_data, g_addr, m_ill, m_vl, i[11:7]); end
         n_vec++; if (g_csr != (m_ill ? 0 : 1)) begin n_err++; $display("FAIL rand_csrwr inst %h got %0d pulses want %0d", i, g_csr, m_ill ? 0 : 1); end
         if (!m_ill) begin
            n_vec++; if (g_s1 !== m_vl || g_s2 !== m_vt) begin n_err++; $display("FAIL rand_csr inst %h rs2 %h got %h/%h want %h/%h", i, r2, g_s1, g_s2, m_vl, m_vt); end
         end
         n_vec++; if (g_lat != 2 || !g_stable || !g_idle || g_to) begin n_err++; $display("FAIL rand_handshake inst %h got lat%0d stable%b idle%b to%b want 2/1/1/0", i, g_lat, g_stable, g_idle, g_to); end
      end
   endtask

   initial begin
      test_reset;
      test_vsetvli;
      test_vsetivli_and_vlmax;
      test_keep_vl;
      test_illegal_vtype;
      test_backpressure;
      test_back_to_back;
      test_reset_mid;
      test_random;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
